// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges in-order pipeline results (port A, priority) with
// long-latency results (port B, buffered in a small FIFO) onto the single
// register-file write port. A later A write to the same register kills any
// older queued B result. A starvation counter stalls A when the FIFO has been
// denied the write port for too long. Publishes a busy mask of in-flight writes.
module wb_write_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                          wb_in_clk,
  input  logic                          wb_in_rstL,
  input  logic                          a_valid,
  input  logic [4:0]                    a_addr,
  input  logic [31:0]                   a_data,
  output logic                          a_stall,
  input  logic                          b_valid,
  output logic                          b_ready,
  input  logic [4:0]                    b_addr,
  input  logic [31:0]                   b_data,
  output logic [37:0]                   write_obus,
  output logic [31:0]                   busy_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [FIFO_DEPTH-1:0] live;
  logic [4:0]            addr_q [FIFO_DEPTH];
  logic [31:0]           data_q [FIFO_DEPTH];
  logic [AW-1:0]         head;
  logic [AW-1:0]         tail;
  logic [CW-1:0]         count;
  logic [SW-1:0]         sc;

  logic                  we_q;
  logic [4:0]            waddr_q;
  logic [31:0]           wdata_q;

  logic fifo_empty;
  logic fifo_full;
  logic a_eff;
  logic sel_a;
  logic pop;
  logic push;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign b_ready    = !fifo_full;
  assign a_stall    = (sc == SW'(STARVE_MAX)) && !fifo_empty;

  assign a_eff = a_valid && (a_addr != 5'd0);
  assign sel_a = a_eff && !a_stall;
  assign pop   = !sel_a && !fifo_empty;
  // Address-0 handshakes complete but are dropped here.
  assign push  = b_valid && b_ready && (b_addr != 5'd0);

  assign write_obus = {we_q, waddr_q, wdata_q};
  assign fifo_count = count;

  // FIFO storage, pointers, occupancy, and kill of entries superseded by A.
  always_ff @(posedge wb_in_clk or negedge wb_in_rstL) begin
    if (!wb_in_rstL) begin
      live  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      // Popped slots lose their live bit so the busy mask only sees occupied entries.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (pop && (head == AW'(i))) begin
          live[i] <= 1'b0;
        end else if (sel_a && live[i] && (addr_q[i] == a_addr)) begin
          live[i] <= 1'b0;
        end
      end
      // A same-cycle A write to the same register is younger, so the new entry starts dead.
      if (push) begin
        live[tail]   <= !(sel_a && (b_addr == a_addr));
        addr_q[tail] <= b_addr;
        data_q[tail] <= b_data;
        tail         <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Starvation counter: counts cycles a non-empty FIFO goes without a pop.
  always_ff @(posedge wb_in_clk or negedge wb_in_rstL) begin
    if (!wb_in_rstL) begin
      sc <= '0;
    end else if (pop || fifo_empty) begin
      sc <= '0;
    end else if (sc != SW'(STARVE_MAX)) begin
      sc <= sc + 1'b1;
    end
  end

  // Output register: A has priority, otherwise drain the FIFO head.
  always_ff @(posedge wb_in_clk or negedge wb_in_rstL) begin
    if (!wb_in_rstL) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (sel_a) begin
      we_q    <= 1'b1;
      waddr_q <= a_addr;
      wdata_q <= a_data;
    end else if (pop) begin
      we_q    <= live[head];
      waddr_q <= addr_q[head];
      wdata_q <= data_q[head];
    end else begin
      we_q    <= 1'b0;
    end
  end

  // Busy mask: every live queued destination plus the write currently on the bus.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (live[i]) begin
        busy_mask[addr_q[i]] = 1'b1;
      end
    end
    if (we_q) begin
      busy_mask[waddr_q] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed testbench for wb_write_arbiter with hand-computed expectations.
module tb_wb_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_stall;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic [37:0] write_obus;
  logic [31:0] busy_mask;
  logic [2:0]  fifo_count;

  int n_cmp = 0;
  int n_bad = 0;

  wb_write_arbiter #(.FIFO_DEPTH(4), .STARVE_MAX(8)) dut (
    .wb_in_clk  (clk),
    .wb_in_rstL (rst_n),
    .a_valid    (a_valid),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .a_stall    (a_stall),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .write_obus (write_obus),
    .busy_mask  (busy_mask),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] wb(input logic we, input logic [4:0] ad, input logic [31:0] d);
    return {we, ad, d};
  endfunction

  task automatic idle_in();
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    #12;
    chk("rst_obus",  write_obus, 38'd0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_busy",  busy_mask,  32'd0);
    chk("rst_stall", a_stall,    1'b0);
    chk("rst_bready", b_ready,   1'b1);
    rst_n = 1'b1;
    step();

    // A priority over simultaneous B
    a_valid = 1; a_addr = 5; a_data = 32'h11;
    b_valid = 1; b_addr = 6; b_data = 32'h22;
    step();
    idle_in();
    chk("pri_a_obus", write_obus, wb(1, 5, 32'h11));
    chk("pri_a_cnt",  fifo_count, 3'd1);
    chk("pri_a_busy", busy_mask,  (32'd1 << 5) | (32'd1 << 6));
    step();
    chk("pri_b_obus", write_obus, wb(1, 6, 32'h22));
    chk("pri_b_cnt",  fifo_count, 3'd0);
    chk("pri_b_busy", busy_mask,  32'd1 << 6);
    step();
    chk("pri_idle_obus", write_obus, wb(0, 6, 32'h22));
    chk("pri_idle_busy", busy_mask,  32'd0);

    // Kill: B r7 queued, then A r7 supersedes it
    b_valid = 1; b_addr = 7; b_data = 32'hAA;
    step();
    idle_in();
    chk("kill_q_busy", busy_mask,  32'd1 << 7);
    chk("kill_q_cnt",  fifo_count, 3'd1);
    a_valid = 1; a_addr = 7; a_data = 32'hBB;
    step();
    idle_in();
    chk("kill_a_obus", write_obus, wb(1, 7, 32'hBB));
    chk("kill_a_busy", busy_mask,  32'd1 << 7);
    chk("kill_a_cnt",  fifo_count, 3'd1);
    step();
    chk("kill_pop_obus", write_obus, wb(0, 7, 32'hAA));
    chk("kill_pop_cnt",  fifo_count, 3'd0);
    chk("kill_pop_busy", busy_mask,  32'd0);

    // Full and zero-address handshake
    a_valid = 1; a_addr = 1; a_data = 32'h1000;
    b_valid = 1;
    for (int i = 0; i < 4; i++) begin
      b_addr = 5'(8 + i); b_data = 32'h800 + 32'(i);
      step();
    end
    chk("full_bready", b_ready,    1'b0);
    chk("full_cnt",    fifo_count, 3'd4);
    chk("full_busy",   busy_mask,  (32'd1 << 1) | (32'hF << 8));
    chk("full_obus",   write_obus, wb(1, 1, 32'h1000));
    b_addr = 0; b_data = 32'h999;
    step();
    chk("full_hold_cnt", fifo_count, 3'd4);
    idle_in();
    step();
    chk("drain0_obus", write_obus, wb(1, 8, 32'h800));
    chk("drain0_cnt",  fifo_count, 3'd3);
    chk("r0_bready",   b_ready,    1'b1);
    a_valid = 1; a_addr = 1; a_data = 32'h1001;
    b_valid = 1; b_addr = 0; b_data = 32'h999;
    step();
    idle_in();
    chk("r0_cnt",  fifo_count, 3'd3);
    chk("r0_obus", write_obus, wb(1, 1, 32'h1001));
    for (int i = 1; i < 4; i++) begin
      step();
      chk("drain_obus", write_obus, wb(1, 5'(8 + i), 32'h800 + 32'(i)));
      chk("drain_cnt",  fifo_count, 3'(3 - i));
    end
    step();
    chk("drain_done_we", write_obus[37], 1'b0);

    // Starvation with one queued entry and A valid every cycle
    a_valid = 1; a_addr = 2; a_data = 32'h200;
    b_valid = 1; b_addr = 12; b_data = 32'hC0;
    step();
    b_valid = 0; b_addr = 0; b_data = 0;
    chk("st_cnt", fifo_count, 3'd1);
    chk("st_stall0", a_stall, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      a_data = 32'h200 + 32'(k);
      step();
      chk("st_obus_a", write_obus, wb(1, 2, 32'h200 + 32'(k)));
      chk("st_stall", a_stall, (k == 8) ? 1'b1 : 1'b0);
    end
    a_data = 32'h2FF;
    step();
    chk("st_pop_obus",  write_obus, wb(1, 12, 32'hC0));
    chk("st_pop_cnt",   fifo_count, 3'd0);
    chk("st_pop_stall", a_stall,    1'b0);
    step();
    chk("st_a_obus", write_obus, wb(1, 2, 32'h2FF));
    idle_in();
    step();

    // Async reset with 3 entries queued and a write on the bus
    a_valid = 1; a_addr = 3; a_data = 32'h300;
    b_valid = 1;
    for (int i = 0; i < 3; i++) begin
      b_addr = 5'(13 + i); b_data = 32'hD0 + 32'(i);
      step();
    end
    idle_in();
    chk("pre_rst_cnt", fifo_count, 3'd3);
    chk("pre_rst_we",  write_obus[37], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_obus",  write_obus, 38'd0);
    chk("arst_cnt",   fifo_count, 3'd0);
    chk("arst_busy",  busy_mask,  32'd0);
    chk("arst_bready", b_ready,   1'b1);
    chk("arst_stall", a_stall,    1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_cnt", fifo_count, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
